// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern transmitter and its companion 0101 detector.
// Holds the state encodings and the default idle line level.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2,
    StFin  = 2'd3
  } seq_state_e;

  // Detector states; A is the park state reached by holding the line high.
  typedef enum logic [1:0] {
    DetA = 2'd0,
    DetB = 2'd1,
    DetC = 2'd2,
    DetD = 2'd3
  } det_state_e;

  localparam logic IdleLvlDefault = 1'b1;

endpackage

// File: rtl/seq_shift_out.sv
// Loadable MSB-first shift register with a bit-index counter.
// first_bit flags index PAT_W-1 and last_bit flags index 0.
module seq_shift_out #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             bit_out,
  output logic             first_bit,
  output logic             last_bit
);

  localparam int unsigned IdxW = $clog2(PAT_W);

  logic [PAT_W-1:0] sh_q;
  logic [IdxW-1:0]  idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (load) begin
      sh_q  <= din;
      idx_q <= IdxW'(PAT_W - 1);
    end else if (shift) begin
      sh_q  <= {sh_q[PAT_W-2:0], 1'b0};
      idx_q <= idx_q - 1'b1;
    end
  end

  assign bit_out   = sh_q[PAT_W-1];
  assign first_bit = (idx_q == IdxW'(PAT_W - 1));
  assign last_bit  = (idx_q == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first for repeat_n passes,
// with an optional idle gap between passes. All outputs are registered.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W    = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GAP_W    = 4,
  parameter logic        IDLE_LVL = IdleLvlDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             dout,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  seq_state_e       state_q;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] passes_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             dout_q, bit_valid_q, frame_start_q, busy_q, done_q;

  logic             accept;
  logic             more_passes;
  logic             sh_load, sh_shift;
  logic [PAT_W-1:0] sh_din;
  logic             sh_bit, sh_first, sh_last;

  assign accept      = (state_q == StIdle) && start && !abort && (repeat_n != '0);
  assign more_passes = (passes_q != CNT_W'(1));

  // The shifter is reloaded at the end of every non-final pass, so it is ready
  // whether the next pass follows immediately or after a gap.
  assign sh_load  = accept ||
                    ((state_q == StSend) && !abort && sh_last && more_passes);
  assign sh_shift = (state_q == StSend) && !abort;
  assign sh_din   = (state_q == StIdle) ? pattern : pat_q;

  seq_shift_out #(
    .PAT_W(PAT_W)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .shift    (sh_shift),
    .din      (sh_din),
    .bit_out  (sh_bit),
    .first_bit(sh_first),
    .last_bit (sh_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pat_q         <= '0;
      passes_q      <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      dout_q        <= IDLE_LVL;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else if (abort) begin
      state_q       <= StIdle;
      dout_q        <= IDLE_LVL;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      dout_q        <= IDLE_LVL;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            pat_q    <= pattern;
            passes_q <= repeat_n;
            gap_q    <= gap;
            state_q  <= StSend;
          end else if (start) begin
            state_q <= StFin;
          end
        end
        StSend: begin
          dout_q        <= sh_bit;
          bit_valid_q   <= 1'b1;
          frame_start_q <= sh_first;
          busy_q        <= 1'b1;
          if (sh_last) begin
            if (!more_passes) begin
              state_q <= StFin;
            end else begin
              passes_q <= passes_q - 1'b1;
              if (gap_q != '0) begin
                gap_cnt_q <= gap_q - 1'b1;
                state_q   <= StGap;
              end
            end
          end
        end
        StGap: begin
          busy_q <= 1'b1;
          if (gap_cnt_q == '0) begin
            state_q <= StSend;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        StFin: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dout        = dout_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: each task drives one scenario and checks the packed
// output vector {dout, bit_valid, frame_start, busy, done} cycle by cycle.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [3:0] pattern;
  logic [7:0] repeat_n;
  logic [3:0] gap;
  logic       dout, bit_valid, frame_start, busy, done;

  int checks = 0;
  int errors = 0;

  seq_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .repeat_n   (repeat_n),
    .gap        (gap),
    .dout       (dout),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] obs();
    return {dout, bit_valid, frame_start, busy, done};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; repeat_n = '0; gap = '0;
    tick(); tick();
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL reset obs=%b exp=10000", obs());
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL idle_after_reset obs=%b exp=10000", obs());
    end
  endtask

  task automatic test_no_gap();
    logic [3:0] p;
    logic [4:0] e;
    p = 4'b0101;
    pattern = p; repeat_n = 8'd3; gap = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      e = {p[3 - (i % 4)], 1'b1, (i % 4) == 0, 1'b1, 1'b0};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL no_gap cyc=%0d obs=%b exp=%b", i, obs(), e);
      end
    end
    tick();
    checks++;
    if (obs() !== 5'b10001) begin
      errors++;
      $display("FAIL no_gap_done obs=%b exp=10001", obs());
    end
    tick();
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL no_gap_after obs=%b exp=10000", obs());
    end
  endtask

  task automatic test_gap();
    logic [10:0] ed, ev, ef;
    logic [4:0]  e;
    ed = 11'b1100_111_1100;
    ev = 11'b1111_000_1111;
    ef = 11'b1000_000_1000;
    pattern = 4'b1100; repeat_n = 8'd2; gap = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      e = {ed[10 - i], ev[10 - i], ef[10 - i], 1'b1, 1'b0};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL gap cyc=%0d obs=%b exp=%b", i, obs(), e);
      end
    end
    tick();
    checks++;
    if (obs() !== 5'b10001) begin
      errors++;
      $display("FAIL gap_done obs=%b exp=10001", obs());
    end
  endtask

  task automatic test_zero_repeat();
    pattern = 4'b0000; repeat_n = 8'd0; gap = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL zero_rep_c1 obs=%b exp=10000", obs());
    end
    tick();
    checks++;
    if (obs() !== 5'b10001) begin
      errors++;
      $display("FAIL zero_rep_c2 obs=%b exp=10001", obs());
    end
    tick();
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL zero_rep_c3 obs=%b exp=10000", obs());
    end
  endtask

  task automatic test_abort();
    logic [4:0] e;
    logic [3:0] p;
    pattern = 4'b1010; repeat_n = 8'd4; gap = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    // Third bit of pass 1 is on the line now.
    checks++;
    if (obs() !== 5'b11010) begin
      errors++;
      $display("FAIL abort_bit3 obs=%b exp=11010", obs());
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL abort_idle obs=%b exp=10000", obs());
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs() !== 5'b10000) begin
        errors++;
        $display("FAIL abort_quiet cyc=%0d obs=%b exp=10000", i, obs());
      end
    end
    // Abort and start together: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL abort_vs_start obs=%b exp=10000", obs());
    end
    p = 4'b0110;
    pattern = p; repeat_n = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = {p[3 - i], 1'b1, i == 0, 1'b1, 1'b0};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL abort_restart cyc=%0d obs=%b exp=%b", i, obs(), e);
      end
    end
    tick();
    checks++;
    if (obs() !== 5'b10001) begin
      errors++;
      $display("FAIL abort_restart_done obs=%b exp=10001", obs());
    end
  endtask

  task automatic test_busy_ignore();
    logic [8:0] ed, ev, ef;
    logic [4:0] e;
    ed = 9'b1011_1_1011;
    ev = 9'b1111_0_1111;
    ef = 9'b1000_0_1000;
    pattern = 4'b1011; repeat_n = 8'd2; gap = 4'd1; start = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      start = (i % 2) == 0;
      pattern = 4'b0000; repeat_n = 8'd7; gap = 4'd5;
      tick();
      e = {ed[8 - i], ev[8 - i], ef[8 - i], 1'b1, 1'b0};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL busy_ign cyc=%0d obs=%b exp=%b", i, obs(), e);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs() !== 5'b10001) begin
      errors++;
      $display("FAIL busy_ign_done obs=%b exp=10001", obs());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== 5'b10000) begin
        errors++;
        $display("FAIL busy_ign_extra cyc=%0d obs=%b exp=10000", i, obs());
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    logic [3:0] p;
    logic [4:0] e;
    pattern = 4'b1100; repeat_n = 8'd2; gap = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if (obs() !== 5'b10010) begin
      errors++;
      $display("FAIL mid_gap obs=%b exp=10010", obs());
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL gap_reset obs=%b exp=10000", obs());
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL gap_reset_rel obs=%b exp=10000", obs());
    end
    p = 4'b1001;
    pattern = p; repeat_n = 8'd1; gap = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = {p[3 - i], 1'b1, i == 0, 1'b1, 1'b0};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL post_reset cyc=%0d obs=%b exp=%b", i, obs(), e);
      end
    end
    tick();
    checks++;
    if (obs() !== 5'b10001) begin
      errors++;
      $display("FAIL post_reset_done obs=%b exp=10001", obs());
    end
  endtask

  initial begin
    test_reset();
    test_no_gap();
    test_gap();
    test_zero_repeat();
    test_abort();
    test_busy_ignore();
    test_reset_mid_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
